fifo_wr_rr_arbiter: RTL and testbench

//  Round-robin write arbiter that shares one single-clock 8-bit FIFO write port between NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 37 +++
 rtl/fifo_wr_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_rr_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: FSM encoding,
// statistics counter width and default geometry.
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W        = 16;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_idx_i, wrapping at NUM_REQ-1 back to index 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest valid candidate is written last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_idx_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with bursts capped at MAX_BURST beats. Define ARB_STATS_EN for per-producer beat counters.
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DW-1:0]     req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      buf_full,
  output logic                      wr_en,
  output logic [DW-1:0]             buf_in,
  output logic [NUM_REQ-1:0]        gnt,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] beat_cnt,
  input  logic                      stats_clr,
`endif
  output logic                      busy
);

  localparam int            IW        = $clog2(NUM_REQ);
  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;
  logic [IW-1:0]      last_idx_q;
  logic [BW-1:0]      burst_cnt_q;
  logic [BW-1:0]      burst_cnt_d;
  logic               burst_end;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i      (req_valid),
    .last_idx_i (last_idx_q),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // buf_full gates the write path combinationally so no write is issued into a full FIFO.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    buf_in    = '0;
    if (state_q == BURST) begin
      req_ready[last_idx_q] = !buf_full;
      wr_en                 = req_valid[last_idx_q] & !buf_full;
      buf_in                = req_data[int'(last_idx_q)*DW +: DW];
    end
  end

  assign burst_cnt_d = burst_cnt_q + 1'b1;
  assign burst_end   = req_last[last_idx_q] || (burst_cnt_d == BURST_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      last_idx_q  <= IW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (pick_any) begin
            state_q     <= BURST;
            gnt_q       <= pick_gnt;
            busy_q      <= 1'b1;
            last_idx_q  <= pick_idx;
            burst_cnt_q <= '0;
          end
        end
        BURST: begin
          // A stalled beat (full FIFO or producer idle) holds grant and count.
          if (wr_en) begin
            burst_cnt_q <= burst_cnt_d;
            if (burst_end) begin
              state_q <= ARB;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] beat_cnt_q [NUM_REQ];

  // Clear has priority over a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) beat_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          beat_cnt_q[i] <= '0;
        end else if (wr_en && (last_idx_q == IW'(i)) && (beat_cnt_q[i] != '1)) begin
          beat_cnt_q[i] <= beat_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat_cnt
    assign beat_cnt[gi*STAT_W +: STAT_W] = beat_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Self-checking bench for fifo_wr_rr_arbiter: transaction-level grant model,
// a 64-entry FIFO model driving buf_full, and per-producer ordering checks.
module tb_fifo_wr_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 8;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            buf_full;
  logic            wr_en;
  logic [DW-1:0]   buf_in;
  logic [N-1:0]    gnt;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
  logic            stats_clr;
`endif

  fifo_wr_rr_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .buf_full  (buf_full),
    .wr_en     (wr_en),
    .buf_in    (buf_in),
    .gnt       (gnt),
`ifdef ARB_STATS_EN
    .beat_cnt  (beat_cnt),
    .stats_clr (stats_clr),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  beat_t         src_q    [N][$];
  logic [DW-1:0] exp_sent [N][$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_log[$];
  int            act_log[$];
  logic [N-1:0]  gate;
  logic [N-1:0]  prev_gnt;
  bit            rd_en, rand_gate, rand_rd;

  // Reference model: granted producer (-1 = none), last granted index, beats in burst.
  int m_gnt, m_last, m_cnt;

  function automatic logic [DW-1:0] mk(input int id, input int seq);
    mk = {2'(id), 6'(seq)};
  endfunction

  task automatic add_beat(input int id, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[id].push_back(b);
    exp_sent[id].push_back(d);
  endtask

  task automatic add_pkt(input int id, input int len, input int seq0);
    for (int s = 0; s < len; s++) add_beat(id, mk(id, seq0 + s), s == len - 1);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    act_log.delete();
    for (int i = 0; i < N; i++) exp_sent[i].delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && gate[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src_q[i][0].data;
        req_last[i]           = src_q[i][0].last;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = 8'($urandom());
        req_last[i]           = 1'($urandom());
      end
    end
    buf_full = (fifo_q.size() >= DEPTH);
  endtask

  function automatic bit work_pending();
    work_pending = (m_gnt >= 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) work_pending = 1'b1;
  endfunction

  // One clock: compare outputs at negedge, step models at posedge, drive new inputs #1 later.
  task automatic cycle();
    logic [N-1:0]  exp_gnt, exp_ready, v, l, acc;
    logic          exp_wr, exp_busy, full, act_wr, found;
    logic [DW-1:0] exp_data, act_data;
    int            gi, j;
    @(negedge clk);
    v        = req_valid;
    l        = req_last;
    full     = buf_full;
    exp_gnt  = '0;
    exp_ready = '0;
    exp_busy = (m_gnt >= 0);
    exp_wr   = 1'b0;
    exp_data = '0;
    if (m_gnt >= 0) begin
      exp_gnt[m_gnt] = 1'b1;
      exp_ready[m_gnt] = !full;
      exp_wr = v[m_gnt] && !full;
      exp_data = req_data[m_gnt*DW +: DW];
    end
    total += 4;
    if (gnt !== exp_gnt) begin
      bad++; $display("FAIL gnt t=%0t: got %b expected %b", $time, gnt, exp_gnt);
    end
    if (busy !== exp_busy) begin
      bad++; $display("FAIL busy t=%0t: got %b expected %b", $time, busy, exp_busy);
    end
    if (req_ready !== exp_ready) begin
      bad++; $display("FAIL req_ready t=%0t: got %b expected %b", $time, req_ready, exp_ready);
    end
    if (wr_en !== exp_wr) begin
      bad++; $display("FAIL wr_en t=%0t: got %b expected %b", $time, wr_en, exp_wr);
    end
    if (exp_wr) begin
      total++;
      if (buf_in !== exp_data) begin
        bad++; $display("FAIL buf_in t=%0t: got %02h expected %02h", $time, buf_in, exp_data);
      end
    end
    if (gnt != '0 && prev_gnt == '0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
      act_log.push_back(gi);
    end
    prev_gnt = gnt;
    acc      = req_valid & req_ready;
    act_wr   = wr_en;
    act_data = buf_in;
    @(posedge clk);
    if (m_gnt < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && v[j]) begin
          found = 1'b1; m_gnt = j; m_last = j; m_cnt = 0;
        end
      end
    end else if (exp_wr) begin
      m_cnt++;
      if (l[m_gnt] || m_cnt == MB) m_gnt = -1;
    end
    if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (act_wr) begin
      fifo_q.push_back(act_data);
      wr_log.push_back(act_data);
    end
    for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (rand_gate) gate = N'($urandom());
    if (rand_rd) rd_en = ($urandom_range(0, 2) == 0);
    #1 drive_inputs();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while (work_pending() && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (work_pending()) begin
      bad++; $display("FAIL %s timeout: work still pending after %0d cycles", name, budget);
    end
    cycle();
    cycle();
  endtask

  task automatic check_order(input string name);
    logic [DW-1:0] exp_b;
    int id, left;
    for (int k = 0; k < wr_log.size(); k++) begin
      id = int'(wr_log[k][7:6]);
      exp_b = (exp_sent[id].size() > 0) ? exp_sent[id].pop_front() : 'x;
      total++;
      if (wr_log[k] !== exp_b) begin
        bad++; $display("FAIL %s order beat %0d: got %02h expected %02h", name, k, wr_log[k], exp_b);
      end
    end
    left = 0;
    for (int i = 0; i < N; i++) left += exp_sent[i].size();
    total++;
    if (left != 0) begin
      bad++; $display("FAIL %s lost beats: got %0d missing expected 0", name, left);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = $urandom();
    buf_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0 || wr_en !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL reset outputs: got gnt=%b busy=%b wr_en=%b ready=%b expected all 0",
                      gnt, busy, wr_en, req_ready);
    end
    req_valid = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset idle: got gnt=%b busy=%b expected 0/0", gnt, busy);
    end
    drive_inputs();
  endtask

  task automatic test_single();
    clear_logs();
    add_beat(0, 8'h11, 1'b0);
    add_beat(0, 8'h22, 1'b0);
    add_beat(0, 8'h33, 1'b1);
    drive_inputs();
    run_idle("single", 20);
    total++;
    if (fifo_q.size() != 3 || fifo_q[0] !== 8'h11 || fifo_q[1] !== 8'h22 || fifo_q[2] !== 8'h33) begin
      bad++; $display("FAIL single fifo: got %p expected 11 22 33", fifo_q);
    end
    total++;
    if (act_log.size() != 1 || act_log[0] != 0) begin
      bad++; $display("FAIL single grants: got %p expected one grant to 0", act_log);
    end
    fifo_q.delete();
  endtask

  task automatic test_round_robin();
    int start;
    clear_logs();
    start = (m_last + 1) % N;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, p);
    drive_inputs();
    run_idle("round_robin", 100);
    total++;
    if (act_log.size() != 3 * N) begin
      bad++; $display("FAIL rr count: got %0d grants expected %0d", act_log.size(), 3 * N);
    end
    for (int k = 0; k < act_log.size(); k++) begin
      total++;
      if (act_log[k] != (start + k) % N) begin
        bad++; $display("FAIL rr order grant %0d: got %0d expected %0d", k, act_log[k], (start + k) % N);
      end
    end
    check_order("rr");
    fifo_q.delete();
  endtask

  task automatic test_max_burst();
    int runs[$];
    int cur = 0;
    clear_logs();
    add_pkt(2, 20, 0);
    add_pkt(0, 1, 0);
    add_pkt(0, 1, 1);
    add_pkt(1, 1, 0);
    add_pkt(1, 1, 1);
    drive_inputs();
    run_idle("max_burst", 200);
    for (int k = 0; k < wr_log.size(); k++) begin
      if (wr_log[k][7:6] == 2'd2) cur++;
      else if (cur > 0) begin
        runs.push_back(cur);
        cur = 0;
      end
    end
    if (cur > 0) runs.push_back(cur);
    total++;
    if (runs.size() != 3 || runs[0] != MB || runs[1] != MB || runs[2] != 4) begin
      bad++; $display("FAIL max_burst runs: got %p expected 8 8 4", runs);
    end
    check_order("max_burst");
    fifo_q.delete();
  endtask

  task automatic test_full();
    clear_logs();
    for (int k = 0; k < DEPTH - 1; k++) fifo_q.push_back(8'hEE);
    rd_en = 1'b0;
    for (int s = 1; s <= 4; s++) add_beat(1, mk(1, s), s == 4);
    drive_inputs();
    repeat (6) cycle();
    total++;
    if (wr_log.size() != 1) begin
      bad++; $display("FAIL full writes while full: got %0d expected 1", wr_log.size());
    end
    total++;
    if (buf_full !== 1'b1 || wr_en !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL full stall: got wr_en=%b ready=%b expected 0/0", wr_en, req_ready);
    end
    rd_en = 1'b1;
    run_idle("full", 50);
    rd_en = 1'b0;
    total++;
    if (wr_log.size() != 4 || wr_log[0] !== 8'h41 || wr_log[1] !== 8'h42 ||
        wr_log[2] !== 8'h43 || wr_log[3] !== 8'h44) begin
      bad++; $display("FAIL full data: got %p expected 41 42 43 44", wr_log);
    end
    fifo_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_logs();
    add_pkt(2, 5, 0);
    drive_inputs();
    while (wr_log.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (wr_log.size() != 2) begin
      bad++; $display("FAIL midrst setup: got %0d beats expected 2", wr_log.size());
    end
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0 || wr_en !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL midrst outputs: got gnt=%b busy=%b wr_en=%b ready=%b expected all 0",
                      gnt, busy, wr_en, req_ready);
    end
    total++;
    if (fifo_q.size() != 2) begin
      bad++; $display("FAIL midrst partial: got %0d entries expected 2", fifo_q.size());
    end
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    m_gnt = -1; m_last = N - 1; m_cnt = 0; prev_gnt = '0;
    @(posedge clk);
    #1;
    clear_logs();
    for (int i = 0; i < N; i++) add_pkt(i, 1, 0);
    drive_inputs();
    run_idle("midrst", 50);
    total++;
    if (act_log.size() != N || act_log[0] != 0 || act_log[1] != 1 || act_log[2] != 2 || act_log[3] != 3) begin
      bad++; $display("FAIL midrst restart: got %p expected 0 1 2 3", act_log);
    end
    fifo_q.delete();
  endtask

  task automatic test_random();
    int seq [N];
    clear_logs();
    for (int k = 0; k < DEPTH - 6; k++) fifo_q.push_back(8'hEE);
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < N; i++) begin
        int len = $urandom_range(1, 12);
        add_pkt(i, len, seq[i]);
        seq[i] += len;
      end
    rand_gate = 1'b1;
    rand_rd   = 1'b1;
    gate      = N'($urandom());
    drive_inputs();
    run_idle("random", 4000);
    rand_gate = 1'b0;
    rand_rd   = 1'b0;
    rd_en     = 1'b0;
    gate      = '1;
    drive_inputs();
    check_order("random");
    fifo_q.delete();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    clear_logs();
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    total++;
    if (beat_cnt !== '0) begin
      bad++; $display("FAIL stats clear0: got %h expected 0", beat_cnt);
    end
    add_pkt(0, 5, 0);
    add_pkt(3, 2, 0);
    drive_inputs();
    run_idle("stats", 50);
    total++;
    if (beat_cnt[0 +: 16] !== 16'd5 || beat_cnt[16 +: 16] !== 16'd0 ||
        beat_cnt[32 +: 16] !== 16'd0 || beat_cnt[48 +: 16] !== 16'd2) begin
      bad++; $display("FAIL stats counts: got %h expected 0002_0000_0000_0005", beat_cnt);
    end
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    total++;
    if (beat_cnt !== '0) begin
      bad++; $display("FAIL stats clear: got %h expected 0", beat_cnt);
    end
    fifo_q.delete();
  endtask
`endif

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    gate = '1; rd_en = 1'b0; rand_gate = 1'b0; rand_rd = 1'b0;
    m_gnt = -1; m_last = N - 1; m_cnt = 0; prev_gnt = '0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_full();
    test_reset_mid_burst();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
